// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction register and datapath.
// Holds the instruction field bit positions, the instruction format
// enum, the opcodes that select a format, and a helper function
// that classifies an opcode into its format.
package cpu_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMME_HI   = 15;
  localparam int IMME_LO   = 0;
  localparam int JADDR_HI  = 25;
  localparam int JADDR_LO  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_t;

  // R for opcode 0, J for the two jump opcodes, I for everything else.
  // The value 3 can never come out of this function.
  function automatic fmt_t decode_fmt(input logic [5:0] op);
    fmt_t f;
    if (op == OP_RTYPE)                    f = FMT_R;
    else if (op == OP_J || op == OP_JAL)   f = FMT_J;
    else                                   f = FMT_I;
    return f;
  endfunction

endpackage

// File: rtl/ir_fifo.sv
// Prefetch queue for the instruction register: a circular buffer of
// DEPTH 32-bit words with naturally wrapping read/write pointers.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   flush          - drop all queued words (pointers and count cleared)
//   push           - write data into the tail (caller guarantees !full)
//   pop            - advance the head (caller guarantees count > 0)
//   data           - word to write on push
//   head           - word at the head of the queue
//   full           - count has reached DEPTH
//   count          - occupancy, 0..DEPTH
module ir_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              data,
  output logic [31:0]              head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];
  assign full = (count == FULL_COUNT);

  // Storage needs no reset; an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointer/count bookkeeping. A simultaneous push and pop moves both
  // pointers and leaves the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register with prefetch queue for the multicycle CPU.
// Fetched words enter an ir_fifo via a valid/ready handshake; the
// ir_write strobe moves the head word into the IR, whose fields are
// decoded combinationally for the register file and ALU.
// Optional feature: define IR_BYPASS_EN to let an ir_write with an
// empty queue take in_inst directly (zero-cycle fetch-to-IR).
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   flush                   - discard queue and invalidate IR
//   in_valid/in_inst/in_ready - memory-side handshake
//   ir_write                - load next instruction into the IR
//   ir_valid                - IR holds a valid instruction
//   opcode..jaddr, imme_ext - decoded IR fields
//   fmt                     - instruction format (R=0, I=1, J=2)
//   count                   - queue occupancy
module ir_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  input  logic                     ir_write,
  output logic                     ir_valid,
  output logic [5:0]               opcode,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imme,
  output logic [XLEN-1:0]          imme_ext,
  output logic [25:0]              jaddr,
  output logic [1:0]               fmt,
  output logic [$clog2(DEPTH):0]   count
);

  logic [31:0] ir;
  logic [31:0] head;
  logic        full;
  logic        queue_empty;
  logic        bypass_take;
  logic        push;
  logic        pop;

  assign queue_empty = (count == '0);
  assign in_ready    = !rst && !full;

`ifdef IR_BYPASS_EN
  // An empty-queue load grabs the incoming word; it never enters the queue.
  assign bypass_take = ir_write && queue_empty && in_valid;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = ir_write && !queue_empty && !flush;

  ir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .data  (in_inst),
    .head  (head),
    .full  (full),
    .count (count)
  );

  // IR load. Flush only invalidates; the stale IR contents are kept.
  // A load with nothing available is a bubble that leaves the IR as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (ir_write) begin
      if (!queue_empty) begin
        ir       <= head;
        ir_valid <= 1'b1;
      end else if (bypass_take) begin
        ir       <= in_inst;
        ir_valid <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign opcode   = ir[OPCODE_HI:OPCODE_LO];
  assign rs       = ir[RS_HI:RS_LO];
  assign rt       = ir[RT_HI:RT_LO];
  assign rd       = ir[RD_HI:RD_LO];
  assign shamt    = ir[SHAMT_HI:SHAMT_LO];
  assign funct    = ir[FUNCT_HI:FUNCT_LO];
  assign imme     = ir[IMME_HI:IMME_LO];
  assign jaddr    = ir[JADDR_HI:JADDR_LO];
  assign imme_ext = {{(XLEN-16){imme[15]}}, imme};
  assign fmt      = decode_fmt(opcode);

endmodule
